// File: rtl/dled_scan.sv
// ============================================================================
// Module  : dled_scan
// Brief   : Multiplexed 7-segment scanner with anti-ghost blanking and a
//           per-frame input snapshot. Optional macro DLED_LZ_BLANK_EN
//           enables leading-zero suppression.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dled_scan #(
    parameter int NUM_DIG   = 8,
    parameter int BLANK_CYC = 4
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   div_clk,
    input  logic [4*NUM_DIG-1:0]   data_in,
    input  logic [NUM_DIG-1:0]     dp_in,
    output logic [7:0]             seg,
    output logic [NUM_DIG-1:0]     dig,
    output logic                   frame_start
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_BLANK    = 2'd1;
    localparam logic [1:0] S_SHOW     = 2'd2;
    localparam logic [2:0] LAST_IDX   = 3'(NUM_DIG - 1);
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYC);

    logic        sync1, sync2, sync3, tick;
    logic [1:0]  state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  bcnt, bcnt_nxt;
    logic        snap;
    logic [31:0] shadow_data;
    logic [7:0]  shadow_dp;
    logic [7:0]  dig_sel;
    logic [3:0]  nib;
    logic [6:0]  glyph;
    logic [7:0]  lit_seg;
    logic [7:0]  seg_nxt;
    logic [NUM_DIG-1:0] dig_nxt;

    // div_clk is an asynchronous level; tick marks its rising edge
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= div_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign tick = sync2 & ~sync3;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= LAST_IDX;
            bcnt        <= 8'd0;
            shadow_data <= 32'd0;
            shadow_dp   <= 8'd0;
            dig         <= '1;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            bcnt        <= bcnt_nxt;
            dig         <= dig_nxt;
            seg         <= seg_nxt;
            frame_start <= snap;
            if (snap) begin
                shadow_data <= 32'(data_in);
                shadow_dp   <= 8'(dp_in);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        bcnt_nxt  = bcnt;
        snap      = 1'b0;
        if (tick) begin
            idx_nxt   = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
            bcnt_nxt  = BLANK_LOAD;
            state_nxt = S_BLANK;
            snap      = (idx == LAST_IDX);
        end else begin
            case (state)
                S_BLANK: begin
                    if (bcnt != 8'd0) bcnt_nxt  = bcnt - 8'd1;
                    else              state_nxt = S_SHOW;
                end
                default: ;
            endcase
        end
    end

    assign dig_sel = 8'd1 << idx;
    assign nib     = shadow_data[{idx, 2'b00} +: 4];

    always_comb begin
        case (nib)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    end

`ifdef DLED_LZ_BLANK_EN
    logic [7:0] lz_mask;
    logic       lz_run;

    // A digit is suppressed while it and every digit above it is a bare zero
    always_comb begin
        lz_mask = 8'd0;
        lz_run  = 1'b1;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            lz_run     = lz_run & (shadow_data[4*k +: 4] == 4'd0) & ~shadow_dp[k];
            lz_mask[k] = lz_run;
        end
    end

    assign lit_seg = lz_mask[idx] ? 8'hFF : {~shadow_dp[idx], glyph};
`else
    assign lit_seg = {~shadow_dp[idx], glyph};
`endif

    always_comb begin
        dig_nxt = dig;
        seg_nxt = seg;
        if (tick) begin
            dig_nxt = '1;
            seg_nxt = 8'hFF;
        end else if (state == S_BLANK && bcnt == 8'd0) begin
            dig_nxt = ~dig_sel[NUM_DIG-1:0];
            seg_nxt = lit_seg;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dled_scan.sv
// ============================================================================
// Module  : tb_dled_scan
// Brief   : Self-checking bench for dled_scan; two instances (8 digits with
//           4 blank cycles, 5 digits with none) against a cycle-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dled_scan;

    logic        clock   = 1'b0;
    logic        rst_n   = 1'b0;
    logic        div_clk = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic [7:0]  dp_in   = 8'd0;
    logic [7:0]  seg_a, seg_b, dig_a;
    logic [4:0]  dig_b;
    logic        fs_a, fs_b;

    always #5 clock = ~clock;

    dled_scan #(.NUM_DIG(8), .BLANK_CYC(4)) dut_a (
        .clock(clock), .rst_n(rst_n), .div_clk(div_clk),
        .data_in(data_in), .dp_in(dp_in),
        .seg(seg_a), .dig(dig_a), .frame_start(fs_a));

    dled_scan #(.NUM_DIG(5), .BLANK_CYC(0)) dut_b (
        .clock(clock), .rst_n(rst_n), .div_clk(div_clk),
        .data_in(data_in[19:0]), .dp_in(dp_in[4:0]),
        .seg(seg_b), .dig(dig_b), .frame_start(fs_b));

    int errors = 0;
    int checks = 0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int nd [2] = '{8, 5};
    int bc [2] = '{4, 0};

    // Model: current digit, cycles since the last tick, per-frame snapshot
    int          m_idx   [2];
    int          m_since [2];
    bit          m_act   [2];
    bit          m_frame [2];
    logic [31:0] m_data  [2];
    logic [7:0]  m_dp    [2];
    logic [2:0]  hist;          // div_clk seen at the last three edges, [0] newest

    int div_left = 1;
    int div_hi   = 1;
    int div_lo   = 1;
    bit div_rnd  = 0;
    bit data_rnd = 0;

    task automatic check(string tag, logic [7:0] obs, logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic bit lit(int u);
        return m_act[u] && (m_since[u] > bc[u]);
    endfunction

    function automatic logic [7:0] exp_seg(int u);
        int         i;
        logic [3:0] n;
`ifdef DLED_LZ_BLANK_EN
        bit         lz;
`endif
        i = m_idx[u];
        n = m_data[u][i*4 +: 4];
`ifdef DLED_LZ_BLANK_EN
        lz = (i != 0);
        for (int j = i; j < nd[u]; j++)
            if (m_data[u][j*4 +: 4] != 4'd0 || m_dp[u][j]) lz = 0;
        if (lz) return 8'hFF;
`endif
        return {~m_dp[u][i], glyph_tab[n]};
    endfunction

    function automatic logic [7:0] exp_dig(int u);
        logic [7:0] v;
        v = 8'hFF;
        if (lit(u)) v[m_idx[u]] = 1'b0;
        return v;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_idx[u] = nd[u] - 1; m_since[u] = 0; m_act[u] = 0; m_frame[u] = 0;
            m_data[u] = 32'd0; m_dp[u] = 8'd0;
        end
        hist = 3'b000;
    endtask

    task automatic model_edge();
        bit tk;
        tk = hist[1] & ~hist[2];
        for (int u = 0; u < 2; u++) begin
            if (tk) begin
                m_idx[u]   = (m_idx[u] + 1) % nd[u];
                m_since[u] = 0;
                m_act[u]   = 1;
                m_frame[u] = (m_idx[u] == 0);
                if (m_frame[u]) begin
                    m_data[u] = (u == 0) ? data_in : {12'd0, data_in[19:0]};
                    m_dp[u]   = (u == 0) ? dp_in   : {3'd0, dp_in[4:0]};
                end
            end else begin
                m_frame[u] = 0;
                if (m_since[u] < 1000) m_since[u]++;
            end
        end
        hist = {hist[1:0], div_clk};
    endtask

    task automatic drive_next();
        if (div_left <= 1) begin
            div_clk  = ~div_clk;
            div_left = div_rnd ? int'($urandom_range(1, 12)) : (div_clk ? div_hi : div_lo);
        end else begin
            div_left--;
        end
        if (data_rnd && $urandom_range(0, 31) == 0) begin
            data_in = $urandom >> (4 * $urandom_range(0, 8));
            dp_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (rst_n) model_edge(); else model_reset();
        @(negedge clock);
        check("dig_a", dig_a, exp_dig(0));
        check("seg_a", seg_a, lit(0) ? exp_seg(0) : 8'hFF);
        check("fs_a",  {7'd0, fs_a}, {7'd0, m_frame[0]});
        check("dig_b", {3'b111, dig_b}, exp_dig(1));
        check("seg_b", seg_b, lit(1) ? exp_seg(1) : 8'hFF);
        check("fs_b",  {7'd0, fs_b}, {7'd0, m_frame[1]});
        drive_next();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until(int target, bit need_lit, int budget);
        bit found;
        found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            found = (m_idx[0] == target) && (!need_lit || lit(0));
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL wait_digit observed=timeout expected=digit %0d", target);
        end
    endtask

    initial begin
        model_reset();
        // Reset held with div_clk toggling
        rst_n = 1'b0; div_hi = 1; div_lo = 1;
        run(5);

        // Scan walk
        data_in = 32'h76543210; dp_in = 8'h00; div_hi = 10; div_lo = 10;
        rst_n = 1'b1;
        run_until(0, 1, 400);
        check("scan_d0_seg", seg_a, 8'hC0);
        check("scan_d0_dig", dig_a, 8'hFE);
        run_until(7, 1, 400);
        check("scan_d7_seg", seg_a, 8'hF8);
        check("scan_d7_dig", dig_a, 8'h7F);
        run(330);

        // Mid-frame data change must not tear
        run_until(3, 0, 400);
        data_in = 32'hFFFFFFFF;
        run_until(5, 1, 400);
        check("tear_old_d5", seg_a, 8'h92);
        run_until(0, 1, 400);
        check("tear_new_d0", seg_a, 8'h8E);
        run(200);

        // Ticks every two clocks
        div_hi = 1; div_lo = 1; div_left = 1;
        run(60);

        // Leading-zero patterns
        div_hi = 10; div_lo = 10;
        data_in = 32'h00000120;
        run(360);
        run_until(7, 1, 400);
`ifdef DLED_LZ_BLANK_EN
        check("lz_d7", seg_a, 8'hFF);
`else
        check("lz_d7", seg_a, 8'hC0);
`endif
        data_in = 32'h00000000;
        run(360);

        // Randomised traffic
        div_rnd = 1; data_rnd = 1;
        run(3000);

        // Asynchronous reset while a digit is shown
        div_rnd = 0; data_rnd = 0; div_hi = 10; div_lo = 10;
        data_in = 32'h76543210; dp_in = 8'h00;
        run_until(5, 1, 600);
        #2 rst_n = 1'b0;
        #1;
        check("async_dig_a", dig_a, 8'hFF);
        check("async_seg_a", seg_a, 8'hFF);
        check("async_dig_b", {3'b111, dig_b}, 8'hFF);
        check("async_seg_b", seg_b, 8'hFF);
        model_reset();
        run(3);
        rst_n = 1'b1;
        run_until(0, 1, 400);
        check("post_rst_d0_seg", seg_a, 8'hC0);
        check("post_rst_d0_dig", dig_a, 8'hFE);
        run(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
